// File: rtl/front_panel_conditioner.sv
// Front-panel input stage: 2-FF synchronizers, a one-hot key debounce FSM with rollover
// rejection, and per-button debouncers that produce active-low one-cycle strobes and a door level.
module front_panel_conditioner #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [9:0] key_raw,
  input  logic       start_raw_,
  input  logic       stop_raw_,
  input  logic       clear_raw_,
  input  logic       door_raw,
  output logic [9:0] keypad,
  output logic       start_,
  output logic       stop_,
  output logic       clear_,
  output logic       door_closed
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0] BTN_IDLE = 4'b0111;
  localparam int START = 0;
  localparam int STOP  = 1;
  localparam int CLEAR = 2;
  localparam int DOOR  = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    QUALIFY = 2'd1,
    HELD    = 2'd2,
    RELEASE = 2'd3
  } key_state_t;

  function automatic logic is_onehot(input logic [9:0] v);
    return (v != 10'd0) && ((v & (v - 10'd1)) == 10'd0);
  endfunction

  logic [9:0]       key_meta_r, key_sync_r;
  logic [3:0]       btn_meta_r, btn_sync_r;
  logic [3:0]       btn_raw_s;
  key_state_t       state_r, state_nxt_s;
  logic [9:0]       key_cap_r, key_cap_nxt_s, keypad_nxt_s;
  logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
  logic [3:0]       db_r, db_nxt_s, fall_s;
  logic [CNT_W-1:0] bcnt_r [4];
  logic [CNT_W-1:0] bcnt_nxt_s [4];

  assign btn_raw_s = {door_raw, clear_raw_, stop_raw_, start_raw_};

  // Two-stage synchronizers; reset loads the idle pattern so reset never looks like a press.
  always_ff @(posedge clock) begin
    if (reset) begin
      key_meta_r <= 10'd0;
      key_sync_r <= 10'd0;
      btn_meta_r <= BTN_IDLE;
      btn_sync_r <= BTN_IDLE;
    end else begin
      key_meta_r <= key_raw;
      key_sync_r <= key_meta_r;
      btn_meta_r <= btn_raw_s;
      btn_sync_r <= btn_meta_r;
    end
  end

  // Key FSM next-state: keypad only ever carries a fully qualified single key.
  always_comb begin
    state_nxt_s   = state_r;
    key_cap_nxt_s = key_cap_r;
    cnt_nxt_s     = cnt_r;
    keypad_nxt_s  = keypad;
    case (state_r)
      IDLE: begin
        keypad_nxt_s = 10'd0;
        if (is_onehot(key_sync_r)) begin
          key_cap_nxt_s = key_sync_r;
          cnt_nxt_s     = CNT_ONE;
          state_nxt_s   = QUALIFY;
        end else begin
          cnt_nxt_s   = CNT_ZERO;
          state_nxt_s = IDLE;
        end
      end
      QUALIFY: begin
        if (key_sync_r != key_cap_r) begin
          keypad_nxt_s = 10'd0;
          cnt_nxt_s    = CNT_ZERO;
          state_nxt_s  = IDLE;
        end else if (cnt_r == CNT_LAST) begin
          keypad_nxt_s = key_cap_r;
          cnt_nxt_s    = CNT_ZERO;
          state_nxt_s  = HELD;
        end else begin
          cnt_nxt_s = cnt_r + CNT_ONE;
        end
      end
      HELD: begin
        if (key_sync_r == key_cap_r) begin
          keypad_nxt_s = key_cap_r;
        end else begin
          keypad_nxt_s = 10'd0;
          cnt_nxt_s    = CNT_ZERO;
          state_nxt_s  = RELEASE;
        end
      end
      RELEASE: begin
        // Any key still down restarts the all-released window, which blocks rollover.
        keypad_nxt_s = 10'd0;
        if (key_sync_r != 10'd0) begin
          cnt_nxt_s = CNT_ZERO;
        end else if (cnt_r == CNT_LAST) begin
          cnt_nxt_s   = CNT_ZERO;
          state_nxt_s = IDLE;
        end else begin
          cnt_nxt_s = cnt_r + CNT_ONE;
        end
      end
      default: begin
        keypad_nxt_s = 10'd0;
        cnt_nxt_s    = CNT_ZERO;
        state_nxt_s  = IDLE;
      end
    endcase
  end

  // Key FSM state and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r   <= IDLE;
      key_cap_r <= 10'd0;
      cnt_r     <= CNT_ZERO;
      keypad    <= 10'd0;
    end else begin
      state_r   <= state_nxt_s;
      key_cap_r <= key_cap_nxt_s;
      cnt_r     <= cnt_nxt_s;
      keypad    <= keypad_nxt_s;
    end
  end

  // Per-button debounce: accept a new level only after it has been stable long enough.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      db_nxt_s[i]   = db_r[i];
      bcnt_nxt_s[i] = CNT_ZERO;
      if (btn_sync_r[i] == db_r[i]) begin
        bcnt_nxt_s[i] = CNT_ZERO;
      end else if (bcnt_r[i] == CNT_LAST) begin
        db_nxt_s[i]   = btn_sync_r[i];
        bcnt_nxt_s[i] = CNT_ZERO;
      end else begin
        bcnt_nxt_s[i] = bcnt_r[i] + CNT_ONE;
      end
    end
    fall_s = db_r & ~db_nxt_s;
  end

  // Debounce state plus strobes; start yields to a simultaneous stop or clear.
  always_ff @(posedge clock) begin
    if (reset) begin
      db_r   <= BTN_IDLE;
      start_ <= 1'b1;
      stop_  <= 1'b1;
      clear_ <= 1'b1;
      for (int i = 0; i < 4; i++) begin
        bcnt_r[i] <= CNT_ZERO;
      end
    end else begin
      db_r   <= db_nxt_s;
      start_ <= ~(fall_s[START] & ~fall_s[STOP] & ~fall_s[CLEAR]);
      stop_  <= ~fall_s[STOP];
      clear_ <= ~fall_s[CLEAR];
      for (int i = 0; i < 4; i++) begin
        bcnt_r[i] <= bcnt_nxt_s[i];
      end
    end
  end

  assign door_closed = db_r[DOOR];

endmodule

// File: tb/tb_front_panel_conditioner.sv
// Directed bench for front_panel_conditioner with DEBOUNCE_CYCLES=4: run-length vector table
// plus hand-written rollover, strobe-priority and mid-operation reset sequences.
module tb_front_panel_conditioner;

  logic       clock = 1'b0;
  logic       reset;
  logic [9:0] key_raw;
  logic       start_raw_, stop_raw_, clear_raw_, door_raw;
  logic [9:0] keypad;
  logic       start_, stop_, clear_, door_closed;

  int checks = 0;
  int errors = 0;

  front_panel_conditioner #(.DEBOUNCE_CYCLES(4)) dut (
    .clock       (clock),
    .reset       (reset),
    .key_raw     (key_raw),
    .start_raw_  (start_raw_),
    .stop_raw_   (stop_raw_),
    .clear_raw_  (clear_raw_),
    .door_raw    (door_raw),
    .keypad      (keypad),
    .start_      (start_),
    .stop_       (stop_),
    .clear_      (clear_),
    .door_closed (door_closed)
  );

  always #5 clock = ~clock;

  // btn / eout bit order: {door, clear, stop, start}
  typedef struct {
    int         n;
    logic       rst;
    logic [9:0] key;
    logic [3:0] btn;
    logic [9:0] ekey;
    logic [3:0] eout;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input int n, input logic rst, input logic [9:0] key, input logic [3:0] btn,
                     input logic [9:0] ekey, input logic [3:0] eout);
    vec_t v;
    v.n = n; v.rst = rst; v.key = key; v.btn = btn; v.ekey = ekey; v.eout = eout;
    tbl.push_back(v);
  endtask

  task automatic drive(input logic rst, input logic [9:0] key, input logic [3:0] btn);
    reset      = rst;
    key_raw    = key;
    start_raw_ = btn[0];
    stop_raw_  = btn[1];
    clear_raw_ = btn[2];
    door_raw   = btn[3];
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [9:0] ekey, input logic [3:0] eout);
    logic [3:0] outs;
    outs = {door_closed, clear_, stop_, start_};
    checks++;
    if (keypad !== ekey || outs !== eout) begin
      errors++;
      $display("FAIL %s t=%0t keypad=%h want %h {door,clear_,stop_,start_}=%b want %b",
               name, $time, keypad, ekey, outs, eout);
    end
  endtask

  task automatic run(input string name, input int n, input logic [9:0] ekey, input logic [3:0] eout);
    for (int k = 0; k < n; k++) begin
      step();
      check(name, ekey, eout);
    end
  endtask

  initial begin
    drive(1'b1, 10'h000, 4'b0111);

    // reset with key and start held, door closed
    add(3, 1'b1, 10'h004, 4'b1110, 10'h000, 4'b0111);
    add(5, 1'b0, 10'h004, 4'b1110, 10'h000, 4'b0111);
    add(1, 1'b0, 10'h004, 4'b1110, 10'h004, 4'b1110);
    add(2, 1'b0, 10'h004, 4'b1110, 10'h004, 4'b1111);
    add(2, 1'b0, 10'h000, 4'b1111, 10'h004, 4'b1111);
    add(8, 1'b0, 10'h000, 4'b1111, 10'h000, 4'b1111);
    // clean press/release, then a key pressed inside the release window stays blocked
    add(5, 1'b0, 10'h020, 4'b1111, 10'h000, 4'b1111);
    add(5, 1'b0, 10'h020, 4'b1111, 10'h020, 4'b1111);
    add(2, 1'b0, 10'h000, 4'b1111, 10'h020, 4'b1111);
    add(1, 1'b0, 10'h000, 4'b1111, 10'h000, 4'b1111);
    add(10, 1'b0, 10'h002, 4'b1111, 10'h000, 4'b1111);
    add(8, 1'b0, 10'h000, 4'b1111, 10'h000, 4'b1111);
    add(5, 1'b0, 10'h002, 4'b1111, 10'h000, 4'b1111);
    add(3, 1'b0, 10'h002, 4'b1111, 10'h002, 4'b1111);
    add(2, 1'b0, 10'h000, 4'b1111, 10'h002, 4'b1111);
    add(6, 1'b0, 10'h000, 4'b1111, 10'h000, 4'b1111);
    // door opens
    add(5, 1'b0, 10'h000, 4'b0111, 10'h000, 4'b1111);
    add(3, 1'b0, 10'h000, 4'b0111, 10'h000, 4'b0111);
    // bouncing key, then stable
    for (int b = 0; b < 6; b++) begin
      add(2, 1'b0, (b % 2 == 0) ? 10'h001 : 10'h000, 4'b0111, 10'h000, 4'b0111);
    end
    add(5, 1'b0, 10'h001, 4'b0111, 10'h000, 4'b0111);
    add(2, 1'b0, 10'h001, 4'b0111, 10'h001, 4'b0111);
    add(2, 1'b0, 10'h000, 4'b0111, 10'h001, 4'b0111);
    add(6, 1'b0, 10'h000, 4'b0111, 10'h000, 4'b0111);
    // short stop glitch ignored; long stop press gives one strobe
    add(3, 1'b0, 10'h000, 4'b0101, 10'h000, 4'b0111);
    add(8, 1'b0, 10'h000, 4'b0111, 10'h000, 4'b0111);
    add(5, 1'b0, 10'h000, 4'b0101, 10'h000, 4'b0111);
    add(1, 1'b0, 10'h000, 4'b0101, 10'h000, 4'b0101);
    add(14, 1'b0, 10'h000, 4'b0101, 10'h000, 4'b0111);
    add(8, 1'b0, 10'h000, 4'b0111, 10'h000, 4'b0111);

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].key, tbl[i].btn);
      run($sformatf("vec%0d", i), tbl[i].n, tbl[i].ekey, tbl[i].eout);
    end

    // rollover: second key drops keypad, nothing new until all keys released
    drive(1'b0, 10'h008, 4'b0111);
    run("roll_press", 5, 10'h000, 4'b0111);
    run("roll_held", 1, 10'h008, 4'b0111);
    drive(1'b0, 10'h00A, 4'b0111);
    run("roll_two_keys", 2, 10'h008, 4'b0111);
    run("roll_drop", 1, 10'h000, 4'b0111);
    drive(1'b0, 10'h008, 4'b0111);
    run("roll_one_left", 10, 10'h000, 4'b0111);
    drive(1'b0, 10'h000, 4'b0111);
    run("roll_released", 8, 10'h000, 4'b0111);
    drive(1'b0, 10'h020, 4'b0111);
    run("roll_next_wait", 5, 10'h000, 4'b0111);
    run("roll_next_key", 2, 10'h020, 4'b0111);
    drive(1'b0, 10'h000, 4'b0111);
    run("roll_next_rel", 2, 10'h020, 4'b0111);
    run("roll_idle", 6, 10'h000, 4'b0111);

    // start and clear fall together: only clear strobes
    drive(1'b0, 10'h000, 4'b0010);
    run("prio_wait", 5, 10'h000, 4'b0111);
    run("prio_strobe", 1, 10'h000, 4'b0011);
    run("prio_hold", 10, 10'h000, 4'b0111);
    drive(1'b0, 10'h000, 4'b0111);
    run("prio_release", 8, 10'h000, 4'b0111);

    // reset during qualification aborts it; key requalifies from scratch
    drive(1'b0, 10'h040, 4'b0111);
    run("mid_qualify", 4, 10'h000, 4'b0111);
    drive(1'b1, 10'h040, 4'b0111);
    run("mid_reset", 1, 10'h000, 4'b0111);
    drive(1'b0, 10'h040, 4'b0111);
    run("mid_requal", 5, 10'h000, 4'b0111);
    run("mid_accept", 1, 10'h040, 4'b0111);
    drive(1'b0, 10'h000, 4'b0111);
    run("mid_release", 2, 10'h040, 4'b0111);
    run("mid_idle", 6, 10'h000, 4'b0111);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/front_panel_conditioner.md
Name: front_panel_conditioner

Overview:
Front-panel input stage that sits directly upstream of the microwave oven controller. It synchronizes and debounces the raw mechanical inputs: the ten digit keys, start, stop, clear and the door switch. It presents the controller with one clean one-hot key level per press, one-cycle active-low command strobes, and a debounced door level. All outputs are registered.

Parameters:
DEBOUNCE_CYCLES  16  consecutive stable synchronized cycles required to accept any input change; legal range 2..255
CNT_W  $clog2(DEBOUNCE_CYCLES+1)  debounce counter width (derived, not overridden)

Ports:
clock  input  1  single system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
key_raw  input  10  raw digit keys, bit n = digit n, active-high, asynchronous, bouncing
start_raw_  input  1  raw start button, active-low, asynchronous
stop_raw_  input  1  raw stop button, active-low, asynchronous
clear_raw_  input  1  raw clear button, active-low, asynchronous
door_raw  input  1  raw door switch, 1 = closed, asynchronous
keypad  output  10  debounced one-hot key level to controller keypad input
start_  output  1  active-low one-cycle start strobe
stop_  output  1  active-low one-cycle stop strobe
clear_  output  1  active-low one-cycle clear strobe
door_closed  output  1  debounced door level

Behaviour:
- One clock. Reset is synchronous and active-high, named reset; clock port named clock.
- Reset values: keypad=0, start_=stop_=clear_=1, door_closed=0 (door open, safe). Synchronizers load the idle pattern: keys 0, buttons 1, door 0. Key FSM goes to IDLE and all counters clear.
- Reset mid-operation aborts any qualification or strobe. Outputs reach reset values at the reset edge.
- Synchronization: every raw input passes through a 2-FF synchronizer. "Synced" below means the second-stage value. Raw-to-synced latency is 2 edges.
- Key FSM states: IDLE, QUALIFY, HELD, RELEASE. A counter cnt runs in QUALIFY and RELEASE.
  - IDLE: synced exactly one-hot -> capture it into key_cap, set cnt=1, go to QUALIFY. Zero or multi-hot -> stay in IDLE.
  - QUALIFY: synced==key_cap -> cnt++. When cnt reaches DEBOUNCE_CYCLES, keypad<=key_cap on that edge and go to HELD. Synced!=key_cap -> go to IDLE, keypad stays 0.
  - HELD: keypad holds key_cap while synced==key_cap. Any difference (release, or a second key added) -> keypad<=0 on that edge, cnt=0, go to RELEASE.
  - RELEASE: synced==0 -> cnt++. Any nonzero synced -> cnt=0. When cnt reaches DEBOUNCE_CYCLES -> go to IDLE.
  - keypad is always 0 or one-hot; never multi-hot.
  - Key latency: a clean press stable at key_raw asserts keypad DEBOUNCE_CYCLES+2 edges after the raw change.
  - Multi-key (rollover) is rejected: a second key held during HELD drops keypad. No new key is accepted until all keys have been released for DEBOUNCE_CYCLES cycles.
- Button debounce, per start/stop/clear/door independently:
  - Each input has a state register db (reset to idle) and a counter.
  - synced==db -> counter=0. Otherwise counter++; when it reaches DEBOUNCE_CYCLES, db<=synced and counter=0.
  - Glitches shorter than DEBOUNCE_CYCLES never change db.
- Strobes: on the edge where db of start/stop/clear transitions 1->0, the matching output goes 0 for exactly one cycle, then returns to 1. The 0->1 transition (release) produces nothing. Holding a button gives one strobe only.
- Strobe priority: if a start strobe would coincide in the same cycle with a stop or clear strobe, the start strobe is suppressed. stop and clear may strobe together.
- door_closed = db of the door input; level only, no strobe. Latency is DEBOUNCE_CYCLES+2 edges in both directions.
- The key path and button paths are independent. A key and a button may be accepted in the same cycle.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset held 3 cycles with key_raw=10'h004, start_raw_=0, door_raw=1 -> during reset keypad=0, start_=1, door_closed=0. After release, keypad=10'h004 and door_closed=1 at edge 6, start_ low exactly at edge 6 only.
- key_raw=10'h020 held 10 cycles -> keypad=10'h020 from edge 6 onward. key_raw=0 -> keypad=0 at 3rd edge after release. Next key accepted no earlier than 2+4 edges after keypad drops.
- key_raw toggles 10'h001/0 every 2 cycles for 12 cycles, then stable 10'h001 -> keypad stays 0 during bounce, asserts 6 edges after the last toggle.
- Hold 10'h008 to HELD, then add bit 1 (10'h00A) -> keypad=0 within 3 edges. Remove bit 1 while keeping bit 3 -> keypad stays 0 until all keys are released.
- stop_raw_ pulsed low 3 cycles -> stop_ never strobes. stop_raw_ low 20 cycles -> exactly one stop_ low cycle at edge 6.
- start_raw_ and clear_raw_ fall on the same cycle -> clear_ strobes at edge 6 and start_ stays 1 throughout.
